uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 100 ++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-bit midpoint
// qualification, and a bit-centred sampling FSM with framing-error detection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        next_state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          half_hit;
  logic          bit_hit;
  logic          sample_data;
  logic          load_data;
  logic          flag_err;

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);

  // The line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!rx_s) next_state = START;
      START: if (half_hit) next_state = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && (bit_idx == 3'd7)) next_state = STOP;
      STOP:  if (bit_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_busy     = (state != IDLE);
    sample_data = (state == DATA) && bit_hit;
    load_data   = (state == STOP) && bit_hit && rx_s;
    flag_err    = (state == STOP) && bit_hit && !rx_s;
  end

  // Leaving STOP at the stop-bit midpoint lets IDLE catch an immediately
  // following start bit; the counter restarts on every state change.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if ((state == IDLE) || (next_state != state) || bit_hit)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (sample_data) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end

      if (load_data)
        rx_data <= shift;

      rx_valid     <= load_data;
      rx_frame_err <= flag_err;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: frames are built from
// bytes, expected pulses are queued, and a negedge monitor checks them.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  exp_t       exp_q[$];
  int         cyc = 0;
  logic       rst_q = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  int         checks = 0;
  int         errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One 8N1 frame, entered and left on a negedge so frames can abut.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit glitchy);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    e.start  = cyc;
    exp_q.push_back(e);
    rx_in = 1'b0;
    for (int i = 0; i < CPB; i++) begin
      if (i == CPB / 2) checkOutput("busy_in_start", rx_busy, 1);
      @(negedge clk_in);
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < CPB; i++) begin
        rx_in = b[k] ^ (glitchy && (i == 1 || i == 2));
        @(negedge clk_in);
      end
    end
    rx_in = stop_ok;
    repeat (CPB) @(negedge clk_in);
  endtask

  task automatic idleCycles(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic glitchLine();
    rx_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rx_in = 1'b1;
    repeat (8) @(negedge clk_in);
    checkOutput("glitch_back_idle", rx_busy, 0);
  endtask

  task automatic abortedFrame(input logic [7:0] b);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int k = 0; k < 4; k++) begin
      rx_in = b[k];
      repeat (CPB) @(negedge clk_in);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    idleCycles(40);
  endtask

  // Monitor: pops one expectation per output pulse and watches pulse rules.
  always @(negedge clk_in) begin
    exp_t e;
    int   lat;
    if (rst_q) begin
      last_good = 8'h00;
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_rx_valid", rx_valid, 0);
      checkOutput("reset_frame_err", rx_frame_err, 0);
      checkOutput("reset_rx_busy", rx_busy, 0);
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (rx_valid && rx_frame_err)
        checkOutput("valid_and_err_together", 1, 0);
      if (rx_valid && prev_valid)
        checkOutput("valid_pulse_width", 2, 1);
      if (rx_frame_err && prev_err)
        checkOutput("err_pulse_width", 2, 1);
      if (rx_valid || rx_frame_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {rx_valid, rx_frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind_err", rx_frame_err, e.is_err);
          checkOutput("pulse_kind_valid", rx_valid, !e.is_err);
          lat = cyc - e.start;
          checks++;
          if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT_NOM);
          end
          if (!e.is_err) begin
            checkOutput("rx_data_new", rx_data, e.data);
            last_good = e.data;
          end else begin
            checkOutput("rx_data_held_on_err", rx_data, last_good);
          end
        end
      end else begin
        checkOutput("rx_data_stable", rx_data, last_good);
      end
      prev_valid = rx_valid;
      prev_err   = rx_frame_err;
    end
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    bit         gl;
    int         waited;
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk_in);
    reset = 1'b0;
    idleCycles(20);

    applyStimulus(8'h55, 1'b1, 1'b0);
    idleCycles(20);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    idleCycles(20);
    glitchLine();
    idleCycles(10);
    applyStimulus(8'hC3, 1'b0, 1'b0);
    idleCycles(30);
    abortedFrame(8'h96);
    applyStimulus(8'h7E, 1'b1, 1'b0);
    idleCycles(20);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    idleCycles(20);

    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      gl = 1'($urandom_range(0, 1));
      applyStimulus(b, ok, gl);
      if (!ok)
        idleCycles(20 + $urandom_range(0, 10));
      else if ($urandom_range(0, 2) != 0)
        idleCycles($urandom_range(1, 30));
    end
    idleCycles(CPB);

    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    idleCycles(5);
    checkOutput("final_busy", rx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
